// File: rtl/bist_march_ctrl.sv
// March C- sequencer and read comparator driving the SRAM under BIST.
// Define BIST_FAIL_CAPTURE_EN to latch the address/element of the first failing read.
module bist_march_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        fail_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [2:0]        elem_q, elem_d, elem_nxt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              cmp_vld_q;
    logic [DATA_W-1:0] exp_q, rd_exp;
    logic [7:0]        fail_cnt_q, fail_cnt_d;
    logic              is_rw, is_down, rd_op, wr_op, last_addr, restart, mismatch;

    always_comb begin
        is_rw     = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
        rd_op     = (state_q == StRun) && ((elem_q == 3'd5) || (is_rw && !phase_q));
        wr_op     = (state_q == StRun) && ((elem_q == 3'd0) || (is_rw && phase_q));
        last_addr = is_down ? (addr_q == '0) : (addr_q == AddrMax);
        restart   = start && ((state_q == StIdle) || (state_q == StDone));
        rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
        mismatch  = cmp_vld_q && (mem_rdata != exp_q);
    end

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        addr_d   = addr_q;
        phase_d  = phase_q;
        elem_nxt = elem_q + 3'd1;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            StRun: begin
                if (rd_op && is_rw) begin
                    // read half of a read-then-write pair; write the same address next
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = is_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                    end else if (elem_q == 3'd5) begin
                        state_d = StDrain;
                    end else begin
                        elem_d = elem_nxt;
                        addr_d = ((elem_nxt == 3'd3) || (elem_nxt == 3'd4)) ? AddrMax : '0;
                    end
                end
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (restart) begin
            fail_cnt_d = 8'h00;
        end else if (mismatch && (fail_cnt_q != 8'hFF)) begin
            fail_cnt_d = fail_cnt_q + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            elem_q     <= 3'd0;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            cmp_vld_q  <= 1'b0;
            exp_q      <= '0;
            fail_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            cmp_vld_q  <= rd_op;
            exp_q      <= rd_exp;
            fail_cnt_q <= fail_cnt_d;
        end
    end

`ifdef BIST_FAIL_CAPTURE_EN
    logic [ADDR_W-1:0] cmp_addr_q, fail_addr_q;
    logic [2:0]        cmp_elem_q, fail_elem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            cmp_addr_q <= addr_q;
            cmp_elem_q <= elem_q;
            if (restart) begin
                fail_addr_q <= '0;
                fail_elem_q <= 3'd0;
            end else if (mismatch && (fail_cnt_q == 8'h00)) begin
                fail_addr_q <= cmp_addr_q;
                fail_elem_q <= cmp_elem_q;
            end
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
`else
    assign fail_addr = '0;
    assign fail_elem = 3'd0;
`endif

    always_comb begin
        mem_we    = wr_op;
        mem_re    = rd_op;
        mem_addr  = (state_q == StRun) ? addr_q : '0;
        mem_wdata = (wr_op && ((elem_q == 3'd1) || (elem_q == 3'd3))) ? '1 : '0;
        busy      = (state_q == StRun) || (state_q == StDrain);
        done      = (state_q == StDone);
        pass      = done && (fail_cnt_q == 8'h00);
        fail_cnt  = fail_cnt_q;
    end

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Directed bench for bist_march_ctrl: behavioural SRAM with stuck-at fault masks.
// Expectations for fail_addr/fail_elem follow BIST_FAIL_CAPTURE_EN.
module tb_bist_march_ctrl;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, done, pass;
    logic [7:0] fail_cnt;
    logic [3:0] fail_addr;
    logic [2:0] fail_elem;

    int checks = 0;
    int failures = 0;
    int both_cnt = 0;

    logic [7:0] mem [N];
    logic [7:0] sa0 [N];
    logic [7:0] sa1 [N];

    logic       tr_we [200];
    logic       tr_re [200];
    logic [3:0] tr_addr [200];
    logic [7:0] tr_wdata [200];
    logic [7:0] cnt_c1;

    int busy_cnt, done_cyc, e0_bad;

    bist_march_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_cnt  (fail_cnt),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= (mem[mem_addr] & ~sa0[mem_addr]) | sa1[mem_addr];
    end

    always @(negedge clk) if (mem_we && mem_re) both_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa0[i] = 8'h00;
            sa1[i] = 8'h00;
        end
    endtask

    // Start at edge 0; cycle k is observed #1 after edge k. Returns when done is seen.
    task automatic run_test(input bit hold, output int nbusy, output int dcyc);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        cyc = 1;
        nbusy = 0;
        cnt_c1 = fail_cnt;
        while (!done && cyc < 400) begin
            if (busy) nbusy++;
            if (cyc < 200) begin
                tr_we[cyc]    = mem_we;
                tr_re[cyc]    = mem_re;
                tr_addr[cyc]  = mem_addr;
                tr_wdata[cyc] = mem_wdata;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        dcyc = cyc;
    endtask

    task automatic all_zero(input string tag);
        check_eq(tag, {busy, done, pass, fail_cnt, fail_addr, fail_elem,
                       mem_addr, mem_wdata, mem_we, mem_re}, 32'h0);
    endtask

    initial begin
        logic [3:0] exp_fa;
        logic [2:0] exp_fe;
        clear_faults();
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        #12;
        all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free run with trace
        both_cnt = 0;
        run_test(1'b0, busy_cnt, done_cyc);
        check_eq("clean_busy_cycles", busy_cnt, 161);
        check_eq("clean_done_cycle", done_cyc, 162);
        check_eq("clean_pass", pass, 1);
        check_eq("clean_fail_cnt", fail_cnt, 0);
        e0_bad = 0;
        for (int i = 1; i <= N; i++)
            if (!(tr_we[i] && !tr_re[i] && tr_addr[i] == 4'(i - 1) && tr_wdata[i] == 8'h00))
                e0_bad++;
        check_eq("e0_write_trace", e0_bad, 0);
        check_eq("e1_first_read", {tr_re[17], tr_we[17], tr_addr[17]}, {1'b1, 1'b0, 4'd0});
        check_eq("e3_r15", {tr_re[81], tr_we[81], tr_addr[81]}, {1'b1, 1'b0, 4'd15});
        check_eq("e3_w1_15", {tr_re[82], tr_we[82], tr_addr[82], tr_wdata[82]},
                 {1'b1 ^ 1'b1, 1'b1, 4'd15, 8'hFF});
        check_eq("e3_r14", {tr_re[83], tr_we[83], tr_addr[83]}, {1'b1, 1'b0, 4'd14});
        check_eq("e5_last_read", {tr_re[160], tr_we[160], tr_addr[160]}, {1'b1, 1'b0, 4'd15});
        check_eq("drain_strobes", {tr_re[161], tr_we[161], tr_addr[161]}, 0);
        check_eq("we_re_exclusive", both_cnt, 0);

        // Bit 0 of address 5 stuck-at-0
        sa0[5] = 8'h01;
        run_test(1'b0, busy_cnt, done_cyc);
        sa0[5] = 8'h00;
`ifdef BIST_FAIL_CAPTURE_EN
        exp_fa = 4'd5; exp_fe = 3'd2;
`else
        exp_fa = 4'd0; exp_fe = 3'd0;
`endif
        check_eq("sa0_done_cycle", done_cyc, 162);
        check_eq("sa0_fail_cnt", fail_cnt, 2);
        check_eq("sa0_pass", pass, 0);
        check_eq("sa0_fail_addr", fail_addr, exp_fa);
        check_eq("sa0_fail_elem", fail_elem, exp_fe);

        // Bit 7 of address 0 stuck-at-1
        sa1[0] = 8'h80;
        run_test(1'b0, busy_cnt, done_cyc);
        sa1[0] = 8'h00;
`ifdef BIST_FAIL_CAPTURE_EN
        exp_fe = 3'd1;
`else
        exp_fe = 3'd0;
`endif
        check_eq("sa1_first_cycle_clear", cnt_c1, 0);
        check_eq("sa1_fail_cnt", fail_cnt, 3);
        check_eq("sa1_fail_addr", fail_addr, 0);
        check_eq("sa1_fail_elem", fail_elem, exp_fe);

        // Rerun from DONE with faults removed
        run_test(1'b0, busy_cnt, done_cyc);
        check_eq("rerun_first_cycle_clear", cnt_c1, 0);
        check_eq("rerun_pass", pass, 1);
        check_eq("rerun_capture_clear", {fail_addr, fail_elem}, 0);

        // Reset in cycle 50 of RUN
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check_eq("midrun_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        all_zero("midrun_reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        run_test(1'b0, busy_cnt, done_cyc);
        check_eq("post_reset_done_cycle", done_cyc, 162);
        check_eq("post_reset_pass", {pass, fail_cnt}, {1'b1, 8'h00});

        // start held high through RUN
        run_test(1'b1, busy_cnt, done_cyc);
        check_eq("held_start_busy", busy_cnt, 161);
        check_eq("held_start_done_cycle", done_cyc, 162);
        run_test(1'b0, busy_cnt, done_cyc);
        start = 1'b0;
        check_eq("held_rerun_done_cycle", done_cyc, 162);
        check_eq("held_rerun_pass", pass, 1);
        check_eq("final_we_re_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
